soc_system_onchip_memory2_arb: RTL and testbench

Two-port Avalon-MM arbiter in front of the single-port 16384×32 on-chip RAM (14-bit word address, 4-bit byteenable, 1-cycle read latency). It lets two masters, such as the HPS lightweight bridge and a fabric DMA, share the RAM. Each cycle it grants at most one request, drives the RAM's s1 port signals and routes read data back with a registered `readdatavalid`.

---
 rtl/soc_system_onchip_memory2_arb.sv | 147 ++++++++++++++
 tb/tb_soc_system_onchip_memory2_arb.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_onchip_memory2_arb.sv
// soc_system_onchip_memory2_arb
//
// Purpose: shares the single-port 16384x32 on-chip RAM between two
// Avalon-MM masters, for example the HPS lightweight bridge and a fabric DMA.
// Each cycle at most one command is granted. The granted command is driven
// combinationally onto the RAM s1 port. Read data comes back with a
// registered readdatavalid one cycle after the read is accepted.
//
// Configuration macro: SOC_ONCHIP_ARB_RR_EN
//   defined   - round-robin on a tie (the port not granted last wins)
//   undefined - fixed priority (port 0 always wins a tie)
//
// Ports:
//   clk, reset_n              single clock, asynchronous active-low reset
//   sN_address/byteenable     port N word address and write byte lanes (N = 0, 1)
//   sN_read/write/writedata   port N command strobes and write data
//   sN_waitrequest            port N stall; accept = strobe & ~waitrequest
//   sN_readdata/readdatavalid port N read return
//   mem_*                     RAM s1 port (clken tied 1, reset_req tied 0)
//   mem_readdata              RAM read data, one cycle after read issue

module soc_system_onchip_memory2_arb #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  // port 0
  input  logic [ADDR_W-1:0]     s0_address,
  input  logic [DATA_W/8-1:0]   s0_byteenable,
  input  logic                  s0_read,
  input  logic                  s0_write,
  input  logic [DATA_W-1:0]     s0_writedata,
  output logic                  s0_waitrequest,
  output logic [DATA_W-1:0]     s0_readdata,
  output logic                  s0_readdatavalid,
  // port 1
  input  logic [ADDR_W-1:0]     s1_address,
  input  logic [DATA_W/8-1:0]   s1_byteenable,
  input  logic                  s1_read,
  input  logic                  s1_write,
  input  logic [DATA_W-1:0]     s1_writedata,
  output logic                  s1_waitrequest,
  output logic [DATA_W-1:0]     s1_readdata,
  output logic                  s1_readdatavalid,
  // RAM s1 port
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  output logic                  mem_reset_req,
  input  logic [DATA_W-1:0]     mem_readdata
);

  logic ready_q, ready_d;
  logic rd_pend_q, rd_pend_d;
  logic rd_port_q, rd_port_d;
`ifdef SOC_ONCHIP_ARB_RR_EN
  logic last_q, last_d;
`endif

  logic req0, req1;
  logic grant0, grant1;
  logic accept;
  logic sel1;
  logic sel_write;
  logic acc_read;

  // Request decode and grant. A tie is resolved by the last pointer in
  // round-robin mode, or always in favour of port 0 otherwise.
  always_comb begin
    req0 = s0_read | s0_write;
    req1 = s1_read | s1_write;
`ifdef SOC_ONCHIP_ARB_RR_EN
    if (req0 && req1) begin
      grant0 = last_q;
      grant1 = ~last_q;
    end else begin
      grant0 = req0;
      grant1 = req1;
    end
`else
    grant0 = req0;
    grant1 = req1 & ~req0;
`endif
  end

  // A command is issued only once the arbiter is ready. While idle, the RAM
  // lines carry the port 0 values. Write takes precedence over a read on
  // the same port.
  always_comb begin
    accept    = ready_q & (req0 | req1);
    sel1      = accept & grant1;
    sel_write = sel1 ? s1_write : s0_write;
    acc_read  = accept & ~sel_write;
  end

  assign s0_waitrequest = ~ready_q | (req0 & ~grant0);
  assign s1_waitrequest = ~ready_q | (req1 & ~grant1);

  assign mem_address    = sel1 ? s1_address    : s0_address;
  assign mem_byteenable = sel1 ? s1_byteenable : s0_byteenable;
  assign mem_writedata  = sel1 ? s1_writedata  : s0_writedata;
  assign mem_chipselect = accept;
  assign mem_write      = accept & sel_write;
  assign mem_clken      = 1'b1;
  assign mem_reset_req  = 1'b0;

  // The RAM has a single read data bus, so both ports see it. Only the
  // qualifier is steered to the port that issued the read.
  assign s0_readdata      = mem_readdata;
  assign s1_readdata      = mem_readdata;
  assign s0_readdatavalid = rd_pend_q & ~rd_port_q;
  assign s1_readdatavalid = rd_pend_q & rd_port_q;

  always_comb begin
    ready_d   = 1'b1;
    rd_pend_d = acc_read;
    rd_port_d = acc_read ? sel1 : rd_port_q;
`ifdef SOC_ONCHIP_ARB_RR_EN
    last_d    = accept ? sel1 : last_q;
`endif
  end

  // Reset drops any in-flight read. last resets to 1 so that port 0 wins
  // the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q   <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_port_q <= 1'b0;
`ifdef SOC_ONCHIP_ARB_RR_EN
      last_q    <= 1'b1;
`endif
    end else begin
      ready_q   <= ready_d;
      rd_pend_q <= rd_pend_d;
      rd_port_q <= rd_port_d;
`ifdef SOC_ONCHIP_ARB_RR_EN
      last_q    <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_soc_system_onchip_memory2_arb.sv
// Directed testbench for soc_system_onchip_memory2_arb with a behavioural
// 16384x32 RAM (byteenable, 1-cycle read latency) attached to the mem_* port.
// Expected values follow the build: round-robin when SOC_ONCHIP_ARB_RR_EN is
// defined, fixed priority otherwise.

module tb_soc_system_onchip_memory2_arb;

`ifdef SOC_ONCHIP_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [13:0] s0_address, s1_address;
  logic [3:0]  s0_byteenable, s1_byteenable;
  logic        s0_read, s0_write, s1_read, s1_write;
  logic [31:0] s0_writedata, s1_writedata;
  logic        s0_waitrequest, s1_waitrequest;
  logic [31:0] s0_readdata, s1_readdata;
  logic        s0_readdatavalid, s1_readdatavalid;
  logic [13:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken, mem_reset_req;
  logic [31:0] mem_writedata;
  logic [31:0] memReadData;

  int testsRun = 0;
  int testsFailed = 0;

  soc_system_onchip_memory2_arb #(.ADDR_W(14), .DATA_W(32)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .s0_address       (s0_address),
    .s0_byteenable    (s0_byteenable),
    .s0_read          (s0_read),
    .s0_write         (s0_write),
    .s0_writedata     (s0_writedata),
    .s0_waitrequest   (s0_waitrequest),
    .s0_readdata      (s0_readdata),
    .s0_readdatavalid (s0_readdatavalid),
    .s1_address       (s1_address),
    .s1_byteenable    (s1_byteenable),
    .s1_read          (s1_read),
    .s1_write         (s1_write),
    .s1_writedata     (s1_writedata),
    .s1_waitrequest   (s1_waitrequest),
    .s1_readdata      (s1_readdata),
    .s1_readdatavalid (s1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_reset_req    (mem_reset_req),
    .mem_readdata     (memReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM, preloaded on the first clock edge (well inside reset).
  logic [31:0] ram [0:16383];
  logic        preloadDone = 1'b0;

  function automatic logic [31:0] initVal(input int addr);
    if (addr == 16'h3FFF)               return 32'h11223344;
    if (addr < 4)                       return 32'hA000_0000 + 32'(addr);
    if (addr >= 'h100 && addr < 'h104)  return 32'hB000_0000 + 32'(addr - 'h100);
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    if (!preloadDone) begin
      for (int a = 0; a < 16384; a++) ram[a] <= initVal(a);
      preloadDone <= 1'b1;
    end else if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        memReadData <= ram[mem_address];
      end
    end
  end

  // Counts one comparison and reports it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drives all command inputs of one port.
  task automatic applyStimulus(input int port, input logic rd, input logic wr,
                               input logic [13:0] addr, input logic [3:0] be,
                               input logic [31:0] data);
    if (port == 0) begin
      s0_read = rd; s0_write = wr; s0_address = addr; s0_byteenable = be; s0_writedata = data;
    end else begin
      s1_read = rd; s1_write = wr; s1_address = addr; s1_byteenable = be; s1_writedata = data;
    end
  endtask

  task automatic idleBoth();
    applyStimulus(0, 1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
  endtask

  initial begin
    int idx0, idx1, gnt, prevGnt, lastM, rdvCount0, rdvCount1;
    logic [31:0] prevData;
    logic [13:0] expAddr;

    reset_n = 1'b0;
    idleBoth();
    // A request held during reset must not reach the RAM.
    applyStimulus(0, 1'b1, 1'b0, 14'h0005, 4'hF, 32'h0);

    // Reset release
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_wait0", 32'(s0_waitrequest), 32'd1);
      checkOutput("rst_wait1", 32'(s1_waitrequest), 32'd1);
      checkOutput("rst_rdv", 32'({s0_readdatavalid, s1_readdatavalid}), 32'd0);
      checkOutput("rst_cs", 32'({mem_chipselect, mem_write}), 32'd0);
      checkOutput("rst_tie", 32'({mem_clken, mem_reset_req}), 32'b10);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    idleBoth();
    @(negedge clk);
    checkOutput("rel_wait0", 32'(s0_waitrequest), 32'd1);
    checkOutput("rel_wait1", 32'(s1_waitrequest), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rdy_wait0", 32'(s0_waitrequest), 32'd0);
    checkOutput("rdy_wait1", 32'(s1_waitrequest), 32'd0);
    checkOutput("rdy_rdv", 32'({s0_readdatavalid, s1_readdatavalid}), 32'd0);

    // Single-port write then read (port 0)
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, 1'b1, 14'h0010, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("wr0_wait", 32'(s0_waitrequest), 32'd0);
    checkOutput("wr0_cs", 32'({mem_chipselect, mem_write}), 32'b11);
    checkOutput("wr0_addr", 32'(mem_address), 32'h0010);
    checkOutput("wr0_data", mem_writedata, 32'hDEADBEEF);
    checkOutput("wr0_be", 32'(mem_byteenable), 32'hF);
    @(posedge clk); #1;
    applyStimulus(0, 1'b1, 1'b0, 14'h0010, 4'hF, 32'h0);
    @(negedge clk);
    checkOutput("rd0_cs", 32'({mem_chipselect, mem_write}), 32'b10);
    checkOutput("rd0_early_rdv", 32'(s0_readdatavalid), 32'd0);
    @(posedge clk); #1;
    idleBoth();
    @(negedge clk);
    checkOutput("rd0_rdv", 32'({s0_readdatavalid, s1_readdatavalid}), 32'b10);
    checkOutput("rd0_data", s0_readdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rd0_rdv_once", 32'(s0_readdatavalid), 32'd0);
    checkOutput("idle_cs", 32'(mem_chipselect), 32'd0);

    // Byte-lane write at the top address (port 1)
    @(posedge clk); #1;
    applyStimulus(1, 1'b0, 1'b1, 14'h3FFF, 4'h1, 32'h000000AA);
    @(negedge clk);
    checkOutput("be1_wait", 32'(s1_waitrequest), 32'd0);
    checkOutput("be1_addr", 32'(mem_address), 32'h3FFF);
    checkOutput("be1_be", 32'(mem_byteenable), 32'h1);
    checkOutput("be1_cs", 32'({mem_chipselect, mem_write}), 32'b11);
    @(posedge clk); #1;
    applyStimulus(1, 1'b1, 1'b0, 14'h3FFF, 4'hF, 32'h0);
    @(negedge clk);
    checkOutput("be1_rd_addr", 32'(mem_address), 32'h3FFF);
    @(posedge clk); #1;
    idleBoth();
    @(negedge clk);
    checkOutput("be1_rdv", 32'({s0_readdatavalid, s1_readdatavalid}), 32'b01);
    checkOutput("be1_data", s1_readdata, 32'h112233AA);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("be1_rdv_once", 32'(s1_readdatavalid), 32'd0);

    // Contention: both ports read every cycle for 8 cycles
    idx0 = 0; idx1 = 0; prevGnt = -1; lastM = 1; rdvCount0 = 0; rdvCount1 = 0;
    prevData = 32'h0;
    for (int c = 0; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c < 8) begin
        applyStimulus(0, 1'b1, 1'b0, 14'(idx0 % 4), 4'hF, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 14'(32'h100 + idx1 % 4), 4'hF, 32'h0);
      end else begin
        idleBoth();
      end
      gnt = RR_EN ? ((lastM == 1) ? 0 : 1) : 0;
      expAddr = (gnt == 0) ? 14'(idx0 % 4) : 14'(32'h100 + idx1 % 4);
      @(negedge clk);
      if (s0_readdatavalid) rdvCount0++;
      if (s1_readdatavalid) rdvCount1++;
      if (c < 8) begin
        checkOutput($sformatf("cont%0d_wait0", c), 32'(s0_waitrequest), 32'(gnt != 0));
        checkOutput($sformatf("cont%0d_wait1", c), 32'(s1_waitrequest), 32'(gnt != 1));
        checkOutput($sformatf("cont%0d_addr", c), 32'(mem_address), 32'(expAddr));
      end
      checkOutput($sformatf("cont%0d_rdv", c), 32'({s0_readdatavalid, s1_readdatavalid}),
                  (prevGnt == 0) ? 32'b10 : (prevGnt == 1) ? 32'b01 : 32'b00);
      if (prevGnt >= 0)
        checkOutput($sformatf("cont%0d_data", c), s0_readdata, prevData);
      if (c < 8) begin
        prevGnt  = gnt;
        prevData = (gnt == 0) ? 32'hA000_0000 + 32'(idx0 % 4) : 32'hB000_0000 + 32'(idx1 % 4);
        if (gnt == 0) idx0++; else idx1++;
        lastM = gnt;
      end else begin
        prevGnt = -1;
      end
    end
    checkOutput("cont_count0", 32'(rdvCount0), RR_EN ? 32'd4 : 32'd8);
    checkOutput("cont_count1", 32'(rdvCount1), RR_EN ? 32'd4 : 32'd0);

    // Simultaneous read+write on port 0 is a write
    @(posedge clk); #1;
    applyStimulus(0, 1'b1, 1'b1, 14'h0020, 4'hF, 32'h5A5A5A5A);
    @(negedge clk);
    checkOutput("rw_cs", 32'({mem_chipselect, mem_write}), 32'b11);
    checkOutput("rw_addr", 32'(mem_address), 32'h0020);
    @(posedge clk); #1;
    idleBoth();
    @(negedge clk);
    checkOutput("rw_no_rdv", 32'({s0_readdatavalid, s1_readdatavalid}), 32'd0);
    @(posedge clk); #1;
    applyStimulus(0, 1'b1, 1'b0, 14'h0020, 4'hF, 32'h0);
    @(posedge clk); #1;
    idleBoth();
    @(negedge clk);
    checkOutput("rw_rdv", 32'(s0_readdatavalid), 32'd1);
    checkOutput("rw_data", s0_readdata, 32'h5A5A5A5A);

    // Reset during an in-flight read
    @(posedge clk); #1;
    applyStimulus(0, 1'b1, 1'b0, 14'h0001, 4'hF, 32'h0);
    @(negedge clk);
    checkOutput("rr_wait0", 32'(s0_waitrequest), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    idleBoth();
    repeat (2) begin
      @(negedge clk);
      checkOutput("rr_no_rdv", 32'({s0_readdatavalid, s1_readdatavalid}), 32'd0);
      checkOutput("rr_wait", 32'({s0_waitrequest, s1_waitrequest}), 32'b11);
      @(posedge clk); #1;
    end
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rr_rel_wait0", 32'(s0_waitrequest), 32'd1);
    checkOutput("rr_rel_rdv", 32'({s0_readdatavalid, s1_readdatavalid}), 32'd0);
    @(posedge clk); #1;
    applyStimulus(0, 1'b1, 1'b0, 14'h0002, 4'hF, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 14'h0101, 4'hF, 32'h0);
    @(negedge clk);
    checkOutput("rr_tie_wait", 32'({s0_waitrequest, s1_waitrequest}), 32'b01);
    checkOutput("rr_tie_addr", 32'(mem_address), 32'h0002);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rr_tie2_wait", 32'({s0_waitrequest, s1_waitrequest}), RR_EN ? 32'b10 : 32'b01);
    checkOutput("rr_tie2_addr", 32'(mem_address), RR_EN ? 32'h0101 : 32'h0002);
    checkOutput("rr_tie_rdv", 32'({s0_readdatavalid, s1_readdatavalid}), 32'b10);
    checkOutput("rr_tie_data", s0_readdata, 32'hA0000002);
    @(posedge clk); #1;
    idleBoth();
    @(negedge clk);
    checkOutput("rr_tie2_rdv", 32'({s0_readdatavalid, s1_readdatavalid}), RR_EN ? 32'b01 : 32'b10);
    checkOutput("rr_tie2_data", s0_readdata, RR_EN ? 32'hB0000001 : 32'hA0000002);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
